// File: rtl/sample_run_ctrl.sv
// Run sequencer for the phase sampler: arms the counters, opens a timed
// sampling window, then streams every counter value out over valid/ready.
module sample_run_ctrl #(
    parameter int          N          = 3,
    parameter logic [31:0] PHASE_BASE = 32'h0000_1000,
    parameter int          IDX_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [31:0]      cfg_counter_max,
    input  logic [31:0]      cfg_counter_cutoff,
    input  logic [31:0]      cfg_run_cycles,
    output logic             smp_rstn,
    output logic [31:0]      smp_counter_max,
    output logic [31:0]      smp_counter_cutoff,
    output logic [31:0]      smp_rd_addr,
    input  logic [31:0]      smp_phase,
    output logic             ph_valid,
    input  logic             ph_ready,
    output logic [31:0]      ph_data,
    output logic [IDX_W-1:0] ph_idx,
    output logic             ph_last,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {
        IDLE, ARM, RUN, FREEZE, FETCH, SEND, DONE
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    state_t            state_reg, state_next;
    logic [31:0]       run_cnt_reg, run_cnt_next;
    logic [31:0]       run_cycles_reg, run_cycles_next;
    logic [31:0]       max_reg, max_next;
    logic [31:0]       cutoff_reg, cutoff_next;
    logic [31:0]       addr_reg, addr_next;
    logic [IDX_W-1:0]  idx_reg, idx_next;
    logic              ph_valid_reg, ph_valid_next;
    logic [31:0]       ph_data_reg, ph_data_next;
    logic [IDX_W-1:0]  ph_idx_reg, ph_idx_next;
    logic              ph_last_reg, ph_last_next;
    logic              done_reg, done_next;
    logic              busy_w;

    assign busy_w = (state_reg != IDLE) && (state_reg != DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            run_cnt_reg    <= '0;
            run_cycles_reg <= '0;
            max_reg        <= '0;
            cutoff_reg     <= '0;
            addr_reg       <= PHASE_BASE;
            idx_reg        <= '0;
            ph_valid_reg   <= 1'b0;
            ph_data_reg    <= '0;
            ph_idx_reg     <= '0;
            ph_last_reg    <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            run_cnt_reg    <= run_cnt_next;
            run_cycles_reg <= run_cycles_next;
            max_reg        <= max_next;
            cutoff_reg     <= cutoff_next;
            addr_reg       <= addr_next;
            idx_reg        <= idx_next;
            ph_valid_reg   <= ph_valid_next;
            ph_data_reg    <= ph_data_next;
            ph_idx_reg     <= ph_idx_next;
            ph_last_reg    <= ph_last_next;
            done_reg       <= done_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        run_cnt_next    = run_cnt_reg;
        run_cycles_next = run_cycles_reg;
        max_next        = max_reg;
        cutoff_next     = cutoff_reg;
        addr_next       = addr_reg;
        idx_next        = idx_reg;
        ph_valid_next   = ph_valid_reg;
        ph_data_next    = ph_data_reg;
        ph_idx_next     = ph_idx_reg;
        ph_last_next    = ph_last_reg;
        done_next       = done_reg;

        case (state_reg)
            IDLE, DONE: begin
                if (start) begin
                    max_next        = cfg_counter_max;
                    cutoff_next     = cfg_counter_cutoff;
                    run_cycles_next = cfg_run_cycles;
                    done_next       = 1'b0;
                    state_next      = ARM;
                end
            end
            ARM: begin
                // A zero-length window still opens for one cycle so the counters see a reset edge.
                run_cnt_next = (run_cycles_reg == 32'd0) ? 32'd1 : run_cycles_reg;
                state_next   = RUN;
            end
            RUN: begin
                run_cnt_next = run_cnt_reg - 32'd1;
                if (run_cnt_reg <= 32'd1) begin
                    state_next = FREEZE;
                end
            end
            FREEZE: begin
                addr_next  = PHASE_BASE;
                idx_next   = '0;
                state_next = FETCH;
            end
            FETCH: begin
                ph_data_next  = smp_phase;
                ph_idx_next   = idx_reg;
                ph_last_next  = (idx_reg == LAST_IDX);
                ph_valid_next = 1'b1;
                state_next    = SEND;
            end
            SEND: begin
                if (ph_valid_reg && ph_ready) begin
                    ph_valid_next = 1'b0;
                    if (ph_last_reg) begin
                        done_next  = 1'b1;
                        state_next = DONE;
                    end else begin
                        idx_next   = idx_reg + IDX_W'(1);
                        addr_next  = addr_reg + 32'd4;
                        state_next = FETCH;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        // Abort overrides whatever the active state decided, including a final handshake.
        if (abort && busy_w) begin
            state_next    = IDLE;
            ph_valid_next = 1'b0;
            addr_next     = PHASE_BASE;
            done_next     = done_reg;
        end
    end

    assign smp_rstn           = (state_reg == RUN);
    assign smp_counter_max    = max_reg;
    assign smp_counter_cutoff = cutoff_reg;
    assign smp_rd_addr        = addr_reg;
    assign ph_valid           = ph_valid_reg;
    assign ph_data            = ph_data_reg;
    assign ph_idx             = ph_idx_reg;
    assign ph_last            = ph_last_reg;
    assign busy               = busy_w;
    assign done               = done_reg;

endmodule

// File: tb/tb_sample_run_ctrl.sv
// Randomized bench for sample_run_ctrl: drives runs, models the sampler as
// a per-run table of phase values and checks window length and readout.
module tb_sample_run_ctrl;
    localparam int          N     = 3;
    localparam logic [31:0] PB    = 32'h0000_1000;
    localparam int          IDX_W = 16;

    logic              clk = 1'b0;
    logic              rst, start, abort;
    logic [31:0]       cfg_counter_max, cfg_counter_cutoff, cfg_run_cycles;
    logic              smp_rstn;
    logic [31:0]       smp_counter_max, smp_counter_cutoff, smp_rd_addr, smp_phase;
    logic              ph_valid, ph_ready, ph_last, busy, done;
    logic [31:0]       ph_data;
    logic [IDX_W-1:0]  ph_idx;

    int checks = 0;
    int errors = 0;

    logic [31:0] phase_tbl [N];

    sample_run_ctrl #(.N(N), .PHASE_BASE(PB), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .cfg_counter_max(cfg_counter_max), .cfg_counter_cutoff(cfg_counter_cutoff),
        .cfg_run_cycles(cfg_run_cycles), .smp_rstn(smp_rstn),
        .smp_counter_max(smp_counter_max), .smp_counter_cutoff(smp_counter_cutoff),
        .smp_rd_addr(smp_rd_addr), .smp_phase(smp_phase),
        .ph_valid(ph_valid), .ph_ready(ph_ready), .ph_data(ph_data),
        .ph_idx(ph_idx), .ph_last(ph_last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Sampler model: counter i answers at PB + 4*i, anything else reads as junk.
    always_comb begin
        smp_phase = 32'hDEAD_BEEF;
        for (int i = 0; i < N; i++)
            if (smp_rd_addr == PB + 32'(4 * i)) smp_phase = phase_tbl[i];
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_rstn"},  64'(smp_rstn), 64'd0);
        check_eq({tag, "_addr"},  64'(smp_rd_addr), 64'(PB));
        check_eq({tag, "_max"},   64'(smp_counter_max), 64'd0);
        check_eq({tag, "_cut"},   64'(smp_counter_cutoff), 64'd0);
        check_eq({tag, "_valid"}, 64'(ph_valid), 64'd0);
        check_eq({tag, "_data"},  64'(ph_data), 64'd0);
        check_eq({tag, "_idx"},   64'(ph_idx), 64'd0);
        check_eq({tag, "_last"},  64'(ph_last), 64'd0);
        check_eq({tag, "_busy"},  64'(busy), 64'd0);
        check_eq({tag, "_done"},  64'(done), 64'd0);
    endtask

    // ready_mode: 0 = always ready, 1 = random, 2 = five stall cycles on idx 1.
    task automatic do_run(input int rc, input int ready_mode, input int abort_at,
                          input bit rst_fetch1, input bit start_in_send, input bit abort_with_start);
        logic [31:0] exp_max, exp_cut, pd;
        logic [IDX_W-1:0] pi;
        int exp_hi, hi, beats, cyc, stall_n;
        bit prev_stall, pulsed;
        for (int i = 0; i < N; i++) phase_tbl[i] = $urandom;
        exp_max = $urandom;
        exp_cut = $urandom;
        exp_hi  = (rc == 0) ? 1 : rc;

        @(negedge clk);
        cfg_counter_max = exp_max; cfg_counter_cutoff = exp_cut; cfg_run_cycles = 32'(rc);
        start = 1'b1; abort = abort_with_start;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check_eq("arm_rstn", 64'(smp_rstn), 64'd0);
        check_eq("arm_busy", 64'(busy), 64'd1);
        check_eq("arm_done", 64'(done), 64'd0);
        check_eq("arm_max",  64'(smp_counter_max), 64'(exp_max));
        check_eq("arm_cut",  64'(smp_counter_cutoff), 64'(exp_cut));
        // Config changes while busy must not disturb the run.
        cfg_counter_max = $urandom; cfg_counter_cutoff = $urandom; cfg_run_cycles = $urandom_range(0, 5);

        hi = 0; cyc = 0;
        @(negedge clk);
        while (smp_rstn && cyc < 1000) begin
            hi++;
            if (abort_at != 0 && hi == abort_at) begin
                abort = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                check_eq("abort_busy",  64'(busy), 64'd0);
                check_eq("abort_rstn",  64'(smp_rstn), 64'd0);
                check_eq("abort_done",  64'(done), 64'd0);
                check_eq("abort_valid", 64'(ph_valid), 64'd0);
                check_eq("abort_addr",  64'(smp_rd_addr), 64'(PB));
                return;
            end
            @(negedge clk);
            cyc++;
        end
        check_eq("run_len", 64'(hi), 64'(exp_hi));
        check_eq("hold_max", 64'(smp_counter_max), 64'(exp_max));
        check_eq("hold_cut", 64'(smp_counter_cutoff), 64'(exp_cut));
        check_eq("freeze_valid", 64'(ph_valid), 64'd0);

        beats = 0; cyc = 0; stall_n = 0; prev_stall = 1'b0; pulsed = 1'b0;
        pd = '0; pi = '0;
        while (beats < N && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (rst_fetch1 && beats == 1 && !ph_valid) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                check_reset_outputs("rst_mid");
                return;
            end
            check_eq("rd_rstn", 64'(smp_rstn), 64'd0);
            check_eq("rd_done", 64'(done), 64'd0);
            if (prev_stall) begin
                check_eq("stall_valid", 64'(ph_valid), 64'd1);
                check_eq("stall_data",  64'(ph_data), 64'(pd));
                check_eq("stall_idx",   64'(ph_idx), 64'(pi));
            end
            case (ready_mode)
                0:       ph_ready = 1'b1;
                1:       ph_ready = ($urandom_range(0, 2) != 0);
                default: begin
                    ph_ready = 1'b1;
                    if (ph_valid && ph_idx == 1 && stall_n < 5) begin
                        ph_ready = 1'b0;
                        stall_n++;
                    end
                end
            endcase
            if (start_in_send && ph_valid && !pulsed) begin
                start = 1'b1; cfg_run_cycles = 32'd50; pulsed = 1'b1;
            end
            prev_stall = ph_valid && !ph_ready;
            pd = ph_data; pi = ph_idx;
            if (ph_valid && ph_ready) begin
                check_eq("beat_data", 64'(ph_data), 64'(phase_tbl[beats]));
                check_eq("beat_idx",  64'(ph_idx), 64'(beats));
                check_eq("beat_last", 64'(ph_last), 64'(beats == N - 1));
                check_eq("beat_addr", 64'(smp_rd_addr), 64'(PB + 32'(4 * beats)));
                beats++;
            end
        end
        check_eq("beat_count", 64'(beats), 64'(N));
        @(negedge clk);
        start = 1'b0;
        check_eq("end_done",  64'(done), 64'd1);
        check_eq("end_busy",  64'(busy), 64'd0);
        check_eq("end_valid", 64'(ph_valid), 64'd0);
        check_eq("end_rstn",  64'(smp_rstn), 64'd0);
        if (ready_mode == 2) check_eq("stall_cycles", 64'(stall_n), 64'd5);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; ph_ready = 1'b0;
        cfg_counter_max = '0; cfg_counter_cutoff = '0; cfg_run_cycles = '0;
        for (int i = 0; i < N; i++) phase_tbl[i] = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_reset_outputs("reset");

        do_run(10, 0, 0, 1'b0, 1'b0, 1'b0);   // basic
        do_run(10, 2, 0, 1'b0, 1'b0, 1'b0);   // backpressure on idx 1
        do_run(0,  0, 0, 1'b0, 1'b0, 1'b0);   // zero-length window
        do_run(10, 0, 4, 1'b0, 1'b0, 1'b0);   // abort on 4th RUN cycle
        do_run(10, 0, 0, 1'b0, 1'b0, 1'b0);   // full run after abort
        do_run(10, 0, 0, 1'b0, 1'b1, 1'b0);   // start ignored during SEND
        do_run(50, 1, 0, 1'b0, 1'b0, 1'b0);   // next run uses 50
        do_run(7,  0, 0, 1'b1, 1'b0, 1'b0);   // rst during FETCH of idx 1
        do_run(3,  0, 0, 1'b0, 1'b0, 1'b1);   // start and abort together in IDLE
        for (int r = 0; r < 8; r++)
            do_run($urandom_range(0, 20), 1, 0, 1'b0, 1'b0, 1'($urandom_range(0, 1)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
